// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port RAM between loader, data and fetch ports.
// One transaction at a time: IDLE -> ISSUE -> (RESP on reads) -> IDLE.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          l_req,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_wd,
  input  logic [DW-1:0] ram_rd,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_L = 2'd1, OWN_D = 2'd2, OWN_I = 2'd3} owner_t;

  state_t        state;
  owner_t        owner;
  logic          rr_fetch;  // 0: data port favoured, 1: fetch port favoured
  logic          sel_l;
  logic          sel_d;
  logic          sel_i;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  // Both read-data buses mirror the RAM; rvalid alone qualifies them.
  assign d_rdata = ram_rd;
  assign i_rdata = ram_rd;

  // Winner selection: loader first, then round-robin between data and fetch.
  always_comb begin
    sel_l = 1'b0;
    sel_d = 1'b0;
    sel_i = 1'b0;
    if (l_req) begin
      sel_l = 1'b1;
    end else if (d_req && i_req) begin
      sel_d = ~rr_fetch;
      sel_i = rr_fetch;
    end else begin
      sel_d = d_req;
      sel_i = i_req;
    end
  end

  // Operand mux feeding the RAM registers from the selected requester.
  always_comb begin
    win_we    = 1'b0;
    win_addr  = i_addr;
    win_wdata = ram_wd;
    if (sel_l) begin
      win_we    = 1'b1;
      win_addr  = l_addr;
      win_wdata = l_wdata;
    end else if (sel_d) begin
      win_we    = d_we;
      win_addr  = d_addr;
      win_wdata = d_wdata;
    end else begin
      win_we    = 1'b0;
      win_addr  = i_addr;
      win_wdata = ram_wd;
    end
  end

  // Transaction sequencer with all outputs registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      owner    <= OWN_NONE;
      rr_fetch <= 1'b0;
      ram_we   <= 1'b0;
      ram_a    <= '0;
      ram_wd   <= '0;
      l_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      i_gnt    <= 1'b0;
      d_rvalid <= 1'b0;
      i_rvalid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          d_rvalid <= 1'b0;
          i_rvalid <= 1'b0;
          if (l_req || d_req || i_req) begin
            ram_we <= win_we;
            ram_a  <= win_addr;
            ram_wd <= win_wdata;
            l_gnt  <= sel_l;
            d_gnt  <= sel_d;
            i_gnt  <= sel_i;
            busy   <= 1'b1;
            state  <= ISSUE;
            if (sel_d) begin
              owner    <= OWN_D;
              rr_fetch <= 1'b1;
            end else if (sel_i) begin
              owner    <= OWN_I;
              rr_fetch <= 1'b0;
            end else begin
              owner    <= OWN_L;
              rr_fetch <= rr_fetch;
            end
          end else begin
            ram_we <= 1'b0;
            l_gnt  <= 1'b0;
            d_gnt  <= 1'b0;
            i_gnt  <= 1'b0;
            busy   <= 1'b0;
          end
        end
        ISSUE: begin
          ram_we <= 1'b0;
          l_gnt  <= 1'b0;
          d_gnt  <= 1'b0;
          i_gnt  <= 1'b0;
          // ram_we still reflects the access the RAM performs on this edge
          if (ram_we) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state    <= RESP;
            d_rvalid <= (owner == OWN_D);
            i_rvalid <= (owner == OWN_I);
          end
        end
        RESP: begin
          d_rvalid <= 1'b0;
          i_rvalid <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state    <= IDLE;
          ram_we   <= 1'b0;
          l_gnt    <= 1'b0;
          d_gnt    <= 1'b0;
          i_gnt    <= 1'b0;
          d_rvalid <= 1'b0;
          i_rvalid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural registered-read RAM.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          l_req, d_req, d_we, i_req;
  logic [AW-1:0] l_addr, d_addr, i_addr;
  logic [DW-1:0] l_wdata, d_wdata;
  logic          l_gnt, d_gnt, d_rvalid, i_gnt, i_rvalid, ram_we, busy;
  logic [DW-1:0] d_rdata, i_rdata, ram_wd, ram_rd;
  logic [AW-1:0] ram_a;

  logic [DW-1:0] mem [0:63];
  logic          pre_we;
  logic [5:0]    pre_idx;
  logic [DW-1:0] pre_data;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .resetn(resetn),
    .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .ram_we(ram_we), .ram_a(ram_a), .ram_wd(ram_wd), .ram_rd(ram_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM model: write and registered read on the same edge, plus a preload port.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (ram_we) mem[ram_a[7:2]] <= ram_wd;
    ram_rd <= mem[ram_a[7:2]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [5:0] idx, input logic [DW-1:0] data);
    pre_we = 1'b1; pre_idx = idx; pre_data = data;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (l_gnt !== 1'b0 || d_gnt !== 1'b0 || i_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: l=%b d=%b i=%b expected 0", l_gnt, d_gnt, i_gnt); end
    checks++; if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: d=%b i=%b expected 0", d_rvalid, i_rvalid); end
    checks++; if (ram_we !== 1'b0 || ram_a !== 32'h0 || ram_wd !== 32'h0 || busy !== 1'b0) begin errors++; $display("FAIL reset_ram: we=%b a=%h wd=%h busy=%b expected 0", ram_we, ram_a, ram_wd, busy); end
  endtask

  task automatic test_round_robin();
    logic exp_d;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0; i_req = 1'b1; i_addr = 32'h4;
    for (int k = 0; k < 4; k++) begin
      exp_d = (k % 2 == 0);
      tick();
      checks++; if (d_gnt !== exp_d || i_gnt !== !exp_d) begin errors++; $display("FAIL rr_gnt[%0d]: d=%b i=%b expected d=%b i=%b", k, d_gnt, i_gnt, exp_d, !exp_d); end
      tick();
      checks++; if (d_rvalid !== exp_d || i_rvalid !== !exp_d) begin errors++; $display("FAIL rr_rvalid[%0d]: d=%b i=%b expected d=%b i=%b", k, d_rvalid, i_rvalid, exp_d, !exp_d); end
      tick();
    end
    d_req = 1'b0; i_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_read();
    i_req = 1'b1; i_addr = 32'h8;
    tick();
    checks++; if (i_gnt !== 1'b1 || ram_a !== 32'h8) begin errors++; $display("FAIL midrst_gnt: gnt=%b a=%h expected 1 00000008", i_gnt, ram_a); end
    i_req = 1'b0;
    resetn = 1'b0;
    #1;
    checks++; if (i_gnt !== 1'b0 || busy !== 1'b0 || ram_a !== 32'h0 || ram_we !== 1'b0) begin errors++; $display("FAIL midrst_async: gnt=%b busy=%b a=%h we=%b expected 0", i_gnt, busy, ram_a, ram_we); end
    tick();
    checks++; if (i_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_rvalid: %b expected 0", i_rvalid); end
    tick();
    resetn = 1'b1;
    i_req = 1'b1; i_addr = 32'h0;
    tick();
    checks++; if (i_gnt !== 1'b1) begin errors++; $display("FAIL midrst_regnt: %b expected 1", i_gnt); end
    i_req = 1'b0;
    tick();
    checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h00000293) begin errors++; $display("FAIL midrst_refetch: v=%b data=%h expected 1 00000293", i_rvalid, i_rdata); end
    tick();
  endtask

  task automatic test_store_load();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h3C; d_wdata = 32'h1;
    tick();
    checks++; if (d_gnt !== 1'b1 || ram_we !== 1'b1 || ram_a !== 32'h3C || ram_wd !== 32'h1) begin errors++; $display("FAIL store_issue: gnt=%b we=%b a=%h wd=%h expected 1 1 0000003c 00000001", d_gnt, ram_we, ram_a, ram_wd); end
    d_req = 1'b0; d_we = 1'b0;
    tick();
    checks++; if (ram_we !== 1'b0 || d_gnt !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL store_done: we=%b gnt=%b busy=%b expected 0", ram_we, d_gnt, busy); end
    d_req = 1'b1; d_addr = 32'h3C;
    tick();
    checks++; if (d_gnt !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL load_gnt: gnt=%b we=%b expected 1 0", d_gnt, ram_we); end
    d_req = 1'b0;
    tick();
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h1 || i_rvalid !== 1'b0) begin errors++; $display("FAIL load_data: v=%b data=%h iv=%b expected 1 00000001 0", d_rvalid, d_rdata, i_rvalid); end
    tick();
    checks++; if (d_rvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL load_end: v=%b busy=%b expected 0", d_rvalid, busy); end
  endtask

  task automatic test_fetch_seq();
    logic [DW-1:0] exp_w [0:2];
    int t_prev = 0;
    exp_w[0] = 32'h00000293; exp_w[1] = 32'h00000313; exp_w[2] = 32'h000003b7;
    for (int k = 0; k < 3; k++) begin
      i_req = 1'b1; i_addr = 32'(k * 4);
      tick();
      checks++; if (i_gnt !== 1'b1) begin errors++; $display("FAIL fetch_gnt[%0d]: %b expected 1", k, i_gnt); end
      i_req = 1'b0;
      tick();
      checks++; if (i_rvalid !== 1'b1 || i_rdata !== exp_w[k]) begin errors++; $display("FAIL fetch_data[%0d]: v=%b data=%h expected 1 %h", k, i_rvalid, i_rdata, exp_w[k]); end
      if (k > 0) begin
        checks++; if (cyc - t_prev !== 3) begin errors++; $display("FAIL fetch_spacing[%0d]: %0d expected 3", k, cyc - t_prev); end
      end
      t_prev = cyc;
      tick();
    end
  endtask

  task automatic test_loader_priority();
    l_req = 1'b1; l_addr = 32'h14; l_wdata = 32'h00128293;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3C;
    i_req = 1'b1; i_addr = 32'h14;
    tick();
    checks++; if (l_gnt !== 1'b1 || d_gnt !== 1'b0 || i_gnt !== 1'b0 || ram_we !== 1'b1) begin errors++; $display("FAIL prio_l: l=%b d=%b i=%b we=%b expected 1 0 0 1", l_gnt, d_gnt, i_gnt, ram_we); end
    l_req = 1'b0;
    tick();
    tick();
    checks++; if (d_gnt !== 1'b1 || i_gnt !== 1'b0 || l_gnt !== 1'b0) begin errors++; $display("FAIL prio_d: l=%b d=%b i=%b expected 0 1 0", l_gnt, d_gnt, i_gnt); end
    d_req = 1'b0;
    tick();
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h1 || i_rvalid !== 1'b0) begin errors++; $display("FAIL prio_dload: v=%b data=%h iv=%b expected 1 00000001 0", d_rvalid, d_rdata, i_rvalid); end
    tick();
    tick();
    checks++; if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin errors++; $display("FAIL prio_i: i=%b d=%b expected 1 0", i_gnt, d_gnt); end
    i_req = 1'b0;
    tick();
    checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h00128293 || d_rvalid !== 1'b0) begin errors++; $display("FAIL prio_raw: v=%b data=%h dv=%b expected 1 00128293 0", i_rvalid, i_rdata, d_rvalid); end
    tick();
  endtask

  task automatic test_stable_operand();
    i_req = 1'b1; i_addr = 32'h4;
    tick();
    i_req = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h55;
    tick();
    checks++; if (d_gnt !== 1'b0 || i_rvalid !== 1'b1 || i_rdata !== 32'h00000313) begin errors++; $display("FAIL hold_resp: dgnt=%b iv=%b data=%h expected 0 1 00000313", d_gnt, i_rvalid, i_rdata); end
    d_addr = 32'h24; d_wdata = 32'h66;
    tick();
    checks++; if (d_gnt !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL hold_idle: dgnt=%b busy=%b expected 0 0", d_gnt, busy); end
    tick();
    checks++; if (d_gnt !== 1'b1 || ram_we !== 1'b1 || ram_a !== 32'h24 || ram_wd !== 32'h66) begin errors++; $display("FAIL stable_op: gnt=%b we=%b a=%h wd=%h expected 1 1 00000024 00000066", d_gnt, ram_we, ram_a, ram_wd); end
    d_req = 1'b0; d_we = 1'b0;
    tick();
    i_req = 1'b1; i_addr = 32'h24;
    tick();
    i_req = 1'b0;
    tick();
    checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h66) begin errors++; $display("FAIL stable_readback: v=%b data=%h expected 1 00000066", i_rvalid, i_rdata); end
    tick();
  endtask

  initial begin
    resetn = 1'b0;
    l_req = 1'b0; d_req = 1'b0; i_req = 1'b0; d_we = 1'b0;
    l_addr = '0; d_addr = '0; i_addr = '0; l_wdata = '0; d_wdata = '0;
    pre_we = 1'b0; pre_idx = '0; pre_data = '0;
    for (int k = 0; k < 64; k++) preload(6'(k), 32'h0);
    preload(6'd0, 32'h00000293);
    preload(6'd1, 32'h00000313);
    preload(6'd2, 32'h000003b7);
    test_reset();
    resetn = 1'b1;
    tick();
    test_round_robin();
    test_reset_mid_read();
    test_store_load();
    test_fetch_seq();
    test_loader_priority();
    test_stable_operand();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
